ccsds_axis_frame_checker: RTL
=============================

// Module: ccsds_axis_frame_checker
// PURPOSE
//  Synthesizable, parametrised successor to the file-based encoder compare bench: joins a reference
//  AXI-Stream and a DUT AXI-Stream (encoder output) word by word, counts bit errors per frame, checks
//  tlast framing against the codeword length, and keeps cumulative frame statistics. Sits beside
//  ccsds_ldpc_encoder in bench and on-FPGA self-test wrappers, with an optional stop-on-first-error mode.
// PARAMETERS
//  width        8    data word width in bits (both streams)
//  frame_len    160  words per codeword (1280 bits / width for stander "1280,1024")
//  cnt_width    16   width of all statistics counters (saturating)
//  stop_on_err  0    1: enter HALT on first bad frame; 0: run continuously
// PORTS
//  clk              in   1          system clock
//  rst_n            in   1          asynchronous active-low reset
//  s_ref_tdata      in   width      expected data
//  s_ref_tvalid     in   1          expected data valid
//  s_ref_tready     out  1          expected data ready
//  s_dut_tdata      in   width      DUT data (connects to encoder m_axis_tdata)
//  s_dut_tvalid     in   1          DUT data valid
//  s_dut_tlast      in   1          DUT end of codeword
//  s_dut_tready     out  1          DUT ready (connects to encoder m_axis_tready)
//  clear            in   1          sync pulse: zero counters, leave HALT
//  frame_done       out  1          1-cycle pulse: frame result valid
//  frame_ok         out  1          last frame had 0 bit errors and correct tlast
//  frame_bit_errs   out  cnt_width  bit errors in last frame
//  frame_tlast_err  out  1          last frame had early or missing tlast
//  frame_cnt        out  cnt_width  frames completed since reset/clear
//  err_frame_cnt    out  cnt_width  frames with frame_ok=0
//  halted           out  1          1 while in HALT
// BEHAVIOUR
//  - Reset (async, rst_n=0): state RUN, word index 0, all outputs and counters 0, readies 0 during reset.
//  - Join: s_ref_tready = s_dut_tvalid & RUN; s_dut_tready = s_ref_tvalid & RUN. Transfer (xfer) only when
//    both valid in RUN; no data is ever consumed from one stream alone. No combinational ready->valid path.
//  - Per xfer: errs = popcount(ref ^ dut), width $clog2(width+1); accumulated into frame accumulator,
//    saturating at 2^cnt_width-1. idx increments 0..frame_len-1.
//  - Frame end on xfer when idx==frame_len-1 OR s_dut_tlast=1. tlast_err = (tlast != (idx==frame_len-1)).
//    Early tlast: frame closes at that word. Missing tlast: frame closes at frame_len-th word; next word starts idx 0.
//  - Latency: frame_done pulses exactly 1 cycle after the closing xfer; frame_bit_errs, frame_ok,
//    frame_tlast_err, frame_cnt, err_frame_cnt update in that same cycle and hold until next frame_done.
//  - Counters saturate at all-ones, never wrap.
//  - FSM: RUN -> HALT when stop_on_err=1 and closing frame is bad (transition with frame_done);
//    HALT -> RUN on clear. In HALT both readies 0, idx frozen at 0.
//  - clear: zeros frame_cnt, err_frame_cnt, frame accumulator, idx, result outputs; clear wins over a
//    simultaneous closing xfer (that frame is discarded, no frame_done). clear mid-frame drops partial frame.
//  - Reset mid-frame: partial frame discarded, no frame_done generated.
// TESTING
//  1 two clean frames (160 words, tlast on word 159) -> 2 frame_done, frame_ok=1, errs=0, frame_cnt=2.
//  2 word 5 XOR 8'h81, word 100 XOR 8'hFF -> frame_bit_errs=10, frame_ok=0, err_frame_cnt=1.
//  3 tlast at word 99 -> frame closes after 100 words, frame_tlast_err=1; next frame idx restarts at 0.
//  4 stop_on_err=1, error in frame 1 -> halted=1, readies 0 for 50 cycles; clear -> halted=0, counts 0.
//  5 random tvalid gaps on both streams (50% each) + DUT tready backpressure -> results identical to test 1.
//  6 cnt_width=4, 20 bad frames -> err_frame_cnt sticks at 15; rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ccsds_axis_frame_checker.sv
// ccsds_axis_frame_checker
// Joins a reference AXI-Stream and a DUT AXI-Stream word by word. For each frame it counts
// bit errors, checks tlast framing against the codeword length, and keeps saturating frame
// statistics. When stop_on_err is set, it can halt on the first bad frame.
module ccsds_axis_frame_checker #(
    parameter int width       = 8,
    parameter int frame_len   = 160,
    parameter int cnt_width   = 16,
    parameter int stop_on_err = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [width-1:0]     s_ref_tdata,
    input  logic                 s_ref_tvalid,
    output logic                 s_ref_tready,
    input  logic [width-1:0]     s_dut_tdata,
    input  logic                 s_dut_tvalid,
    input  logic                 s_dut_tlast,
    output logic                 s_dut_tready,
    input  logic                 clear,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [cnt_width-1:0] frame_bit_errs,
    output logic                 frame_tlast_err,
    output logic [cnt_width-1:0] frame_cnt,
    output logic [cnt_width-1:0] err_frame_cnt,
    output logic                 halted
);

    localparam int EW = $clog2(width + 1);
    localparam int IW = (frame_len > 1) ? $clog2(frame_len) : 1;
    localparam int SW = cnt_width + 1;
    localparam logic [IW-1:0]        LAST_IDX = IW'(frame_len - 1);
    localparam logic [cnt_width-1:0] CNT_MAX  = {cnt_width{1'b1}};
    localparam logic                 STOP_EN  = (stop_on_err != 32'sd0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Number of set bits in a data word, i.e. the bit errors of one xor'ed word pair.
    function automatic logic [EW-1:0] popcount(input logic [width-1:0] v);
        logic [EW-1:0] c;
        c = {EW{1'b0}};
        for (int i = 0; i < width; i++) begin
            c = c + EW'(v[i]);
        end
        return c;
    endfunction

    // Increment by one, but stick at all-ones instead of wrapping.
    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
        return (v == CNT_MAX) ? v : (v + cnt_width'(1'b1));
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IW-1:0]          r_idx;
    logic [cnt_width-1:0]   r_acc;
    logic                   r_frame_done;
    logic                   r_frame_ok;
    logic [cnt_width-1:0]   r_frame_bit_errs;
    logic                   r_frame_tlast_err;
    logic [cnt_width-1:0]   r_frame_cnt;
    logic [cnt_width-1:0]   r_err_frame_cnt;

    logic                   w_run;
    logic                   w_xfer;
    logic [EW-1:0]          w_errs;
    logic                   w_is_last;
    logic                   w_close;
    logic                   w_tlast_err;
    logic [SW-1:0]          w_sum;
    logic [cnt_width-1:0]   w_frame_errs;
    logic                   w_frame_bad;

    // The readies are forced low while rst_n is asserted, so no word is taken during reset.
    assign w_run        = (r_state == ST_RUN) & rst_n;
    assign w_xfer       = s_ref_tvalid & s_dut_tvalid & w_run;
    assign w_errs       = popcount(s_ref_tdata ^ s_dut_tdata);
    assign w_is_last    = (r_idx == LAST_IDX);
    assign w_close      = w_xfer & (w_is_last | s_dut_tlast);
    assign w_tlast_err  = s_dut_tlast ^ w_is_last;
    assign w_sum        = {1'b0, r_acc} + SW'(w_errs);
    assign w_frame_errs = w_sum[SW-1] ? CNT_MAX : w_sum[cnt_width-1:0];
    assign w_frame_bad  = (w_frame_errs != {cnt_width{1'b0}}) | w_tlast_err;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a bad frame halts when stopping is enabled, and clear always resumes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (clear) begin
                    w_next_state = ST_RUN;
                end else if (w_close && STOP_EN && w_frame_bad) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HALT: begin
                if (clear) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // FSM outputs: join handshake, where each side is ready only when the other side has data.
    always_comb begin
        s_ref_tready = 1'b0;
        s_dut_tready = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_RUN: begin
                s_ref_tready = s_dut_tvalid & w_run;
                s_dut_tready = s_ref_tvalid & w_run;
                halted       = 1'b0;
            end
            ST_HALT: begin
                s_ref_tready = 1'b0;
                s_dut_tready = 1'b0;
                halted       = 1'b1;
            end
            default: begin
                s_ref_tready = 1'b0;
                s_dut_tready = 1'b0;
                halted       = 1'b0;
            end
        endcase
    end

    // Frame accumulation and result/statistics registers; clear overrides a closing transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx             <= {IW{1'b0}};
            r_acc             <= {cnt_width{1'b0}};
            r_frame_done      <= 1'b0;
            r_frame_ok        <= 1'b0;
            r_frame_bit_errs  <= {cnt_width{1'b0}};
            r_frame_tlast_err <= 1'b0;
            r_frame_cnt       <= {cnt_width{1'b0}};
            r_err_frame_cnt   <= {cnt_width{1'b0}};
        end else if (clear) begin
            r_idx             <= {IW{1'b0}};
            r_acc             <= {cnt_width{1'b0}};
            r_frame_done      <= 1'b0;
            r_frame_ok        <= 1'b0;
            r_frame_bit_errs  <= {cnt_width{1'b0}};
            r_frame_tlast_err <= 1'b0;
            r_frame_cnt       <= {cnt_width{1'b0}};
            r_err_frame_cnt   <= {cnt_width{1'b0}};
        end else begin
            r_frame_done <= w_close;
            if (w_close) begin
                r_idx             <= {IW{1'b0}};
                r_acc             <= {cnt_width{1'b0}};
                r_frame_ok        <= ~w_frame_bad;
                r_frame_bit_errs  <= w_frame_errs;
                r_frame_tlast_err <= w_tlast_err;
                r_frame_cnt       <= sat_inc(r_frame_cnt);
                if (w_frame_bad) begin
                    r_err_frame_cnt <= sat_inc(r_err_frame_cnt);
                end else begin
                    r_err_frame_cnt <= r_err_frame_cnt;
                end
            end else if (w_xfer) begin
                r_idx <= r_idx + IW'(1'b1);
                r_acc <= w_frame_errs;
            end else begin
                r_idx <= r_idx;
                r_acc <= r_acc;
            end
        end
    end

    assign frame_done      = r_frame_done;
    assign frame_ok        = r_frame_ok;
    assign frame_bit_errs  = r_frame_bit_errs;
    assign frame_tlast_err = r_frame_tlast_err;
    assign frame_cnt       = r_frame_cnt;
    assign err_frame_cnt   = r_err_frame_cnt;

endmodule
